// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: instruction, ALU, state and mux-select encodings shared by the multicycle control slice
package multicycle_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LB = 6'h20, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0c, FN_ADD = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BEQ, C_BNE, C_BLTZ,
    C_J, C_JAL, C_JR, C_SYSCALL, C_ILLEGAL
  } iclass_e;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: combinational instruction classifier and single-cycle ALU control decode
module mc_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output iclass_e            iclass,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic               alu_src,
  output logic               signed_ext,
  output logic               sllv,
  output logic               lb,
  output logic               illegal
);
  alu_op_e op;
  always_comb begin
    iclass = C_ILLEGAL;
    op = ALU_ADD;
    alu_src = 1'b0;
    signed_ext = 1'b0;
    sllv = 1'b0;
    lb = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = C_ALU_R;
        case (funct)
          FN_SLL: op = ALU_SLL;
          FN_SRL: op = ALU_SRL;
          FN_SRA: op = ALU_SRA;
          FN_SLLV: begin
            op = ALU_SLL;
            sllv = 1'b1;
          end
          FN_JR: iclass = C_JR;
          FN_SYSCALL: iclass = C_SYSCALL;
          FN_ADD, FN_ADDU: op = ALU_ADD;
          FN_SUB, FN_SUBU: op = ALU_SUB;
          FN_AND: op = ALU_AND;
          FN_OR: op = ALU_OR;
          FN_XOR: op = ALU_XOR;
          FN_NOR: op = ALU_NOR;
          FN_SLT: op = ALU_SLT;
          FN_SLTU: op = ALU_SLTU;
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_REGIMM, OP_BEQ, OP_BNE: begin
        iclass = opcode == OP_BEQ ? C_BEQ : opcode == OP_BNE ? C_BNE : C_BLTZ;
        op = ALU_SUB;
        signed_ext = 1'b1;
      end
      OP_J: iclass = C_J;
      OP_JAL: iclass = C_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        iclass = C_ALU_I;
        op = opcode == OP_SLTI ? ALU_SLT : opcode == OP_SLTIU ? ALU_SLTU : ALU_ADD;
        alu_src = 1'b1;
        signed_ext = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        iclass = C_ALU_I;
        op = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : opcode == OP_XORI ? ALU_XOR : ALU_LUI;
        alu_src = 1'b1;
      end
      OP_LW, OP_LB, OP_SW: begin
        iclass = opcode == OP_SW ? C_STORE : C_LOAD;
        alu_src = 1'b1;
        signed_ext = 1'b1;
        lb = opcode == OP_LB;
      end
      default: iclass = C_ILLEGAL;
    endcase
  end
  assign alu_ctrl = ALUOP_W'(op);
  assign illegal = iclass == C_ILLEGAL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with halt, cycle and retire counters
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W = 32,
  parameter int HALT_ON_SYSCALL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               neg,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic               mem2reg,
  output logic               lb,
  output logic               sllv,
  output logic               alu_src,
  output logic               signed_ext,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);
  state_e state, next;
  iclass_e iclass;
  logic [ALUOP_W-1:0] dec_alu;
  logic dec_src, dec_sext, dec_sllv, dec_lb, dec_illegal, retire, taken;

  mc_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .opcode(opcode),
    .funct(funct),
    .iclass(iclass),
    .alu_ctrl(dec_alu),
    .alu_src(dec_src),
    .signed_ext(dec_sext),
    .sllv(dec_sllv),
    .lb(dec_lb),
    .illegal(dec_illegal)
  );

  assign taken = (iclass == C_BEQ && zero) || (iclass == C_BNE && !zero) || (iclass == C_BLTZ && neg);

  always_ff @(posedge clk) state <= rst ? S_FETCH : next;

  always_comb begin
    next = state;
    case (state)
      S_FETCH: next = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next = iclass inside {C_J, C_JAL, C_ILLEGAL} ? S_FETCH :
                       iclass == C_SYSCALL ? (HALT_ON_SYSCALL != 0 ? S_HALT : S_FETCH) : S_EXEC;
      S_EXEC: next = iclass inside {C_LOAD, C_STORE} ? S_MEM :
                     iclass inside {C_ALU_R, C_ALU_I} ? S_WB : S_FETCH;
      S_MEM: next = !dmem_ready ? S_MEM : iclass == C_STORE ? S_FETCH : S_WB;
      S_WB: next = S_FETCH;
      S_HALT: next = S_HALT;
      default: next = S_FETCH;
    endcase
  end

  // Strobes are gated by rst so nothing fires in the reset cycle, whatever state we were in.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_sel = PC_PLUS4;
    reg_we = 1'b0;
    reg_dst = DST_RT;
    mem2reg = 1'b0;
    lb = 1'b0;
    sllv = 1'b0;
    alu_src = 1'b0;
    signed_ext = 1'b0;
    alu_ctrl = ALUOP_W'(ALU_ADD);
    halted = 1'b0;
    illegal = 1'b0;
    retire = 1'b0;
    if (!rst)
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we = imem_ready;
          pc_we = imem_ready;
        end
        S_DECODE: begin
          pc_we = iclass inside {C_J, C_JAL};
          pc_sel = pc_we ? PC_JUMP : PC_PLUS4;
          reg_we = iclass == C_JAL;
          reg_dst = reg_we ? DST_RA : DST_RT;
          illegal = dec_illegal;
          retire = iclass inside {C_J, C_JAL, C_ILLEGAL, C_SYSCALL};
        end
        S_EXEC: begin
          alu_ctrl = dec_alu;
          alu_src = dec_src;
          signed_ext = dec_sext;
          sllv = dec_sllv;
          pc_we = taken || iclass == C_JR;
          pc_sel = iclass == C_JR ? PC_RS : taken ? PC_BRANCH : PC_PLUS4;
          retire = iclass inside {C_BEQ, C_BNE, C_BLTZ, C_JR};
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we = iclass == C_STORE;
          retire = dmem_we && dmem_ready;
        end
        S_WB: begin
          reg_we = 1'b1;
          reg_dst = iclass == C_ALU_R ? DST_RD : DST_RT;
          mem2reg = iclass == C_LOAD;
          lb = dec_lb;
          retire = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state != S_HALT) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      instr_cnt <= instr_cnt + CNT_W'(retire);
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against a per-cycle trace model
module tb_multicycle_ctrl;
  localparam int CW = 8;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_LB = 3, K_SW = 4, K_BEQ = 5, K_BNE = 6;
  localparam int K_BLTZ = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_SYS = 11, K_ILL = 12;
  localparam int I_ADD = 0, I_LW = 23, I_SW = 25, I_BEQ = 26, I_JAL = 30, I_ILLOP = 31, I_SYS = 33;

  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic reg_we;
    logic [1:0] reg_dst;
    logic mem2reg, lb, sllv, alu_src, signed_ext;
    logic [3:0] alu_ctrl;
    logic illegal, halted;
  } outs_t;
  typedef struct {
    logic ir, dr;
    outs_t o;
    bit ret;
  } step_t;
  typedef struct {
    logic [5:0] op, fn;
    int kind;
    logic [3:0] alu;
    logic src, sext, sv;
  } ins_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, neg = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, mem2reg, lb, sllv, alu_src, signed_ext, halted, illegal;
  logic [1:0] pc_sel, reg_dst;
  logic [3:0] alu_ctrl;
  logic [CW-1:0] cycle_cnt, instr_cnt;
  logic [CW-1:0] exp_cyc = '0, exp_ins = '0;
  int checks = 0, errors = 0;
  ins_t isa[34];
  step_t trace[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(4), .CNT_W(CW), .HALT_ON_SYSCALL(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .neg(neg),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .lb(lb), .sllv(sllv), .alu_src(alu_src),
    .signed_ext(signed_ext), .alu_ctrl(alu_ctrl), .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  function automatic ins_t mk(input int op, input int fn, input int kind, input int alu, input int src, input int sext, input int sv);
    ins_t d;
    d.op = 6'(op);
    d.fn = 6'(fn);
    d.kind = kind;
    d.alu = 4'(alu);
    d.src = 1'(src);
    d.sext = 1'(sext);
    d.sv = 1'(sv);
    return d;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t sample();
    return '{imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst,
             mem2reg, lb, sllv, alu_src, signed_ext, alu_ctrl, illegal, halted};
  endfunction

  function automatic void push(input logic ir, input logic dr, input outs_t o, input bit ret);
    step_t s;
    s.ir = ir;
    s.dr = dr;
    s.o = o;
    s.ret = ret;
    trace.push_back(s);
  endfunction

  // Expected per-cycle strobes for one instruction, given fetch/memory wait counts and flags.
  function automatic void build(input ins_t d, input int iw, input int dw, input logic z, input logic n);
    outs_t o;
    bit taken;
    for (int i = 0; i < iw; i++) begin
      o = '0;
      o.imem_req = 1'b1;
      push(1'b0, rb(), o, 1'b0);
    end
    o = '0;
    o.imem_req = 1'b1;
    o.ir_we = 1'b1;
    o.pc_we = 1'b1;
    push(1'b1, rb(), o, 1'b0);
    o = '0;
    if (d.kind == K_J || d.kind == K_JAL) begin
      o.pc_we = 1'b1;
      o.pc_sel = 2'd2;
      o.reg_we = d.kind == K_JAL;
      o.reg_dst = d.kind == K_JAL ? 2'd2 : 2'd0;
      push(rb(), rb(), o, 1'b1);
      return;
    end
    if (d.kind == K_ILL || d.kind == K_SYS) begin
      o.illegal = d.kind == K_ILL;
      push(rb(), rb(), o, 1'b1);
      return;
    end
    push(rb(), rb(), o, 1'b0);
    o.alu_ctrl = d.alu;
    o.alu_src = d.src;
    o.signed_ext = d.sext;
    o.sllv = d.sv;
    if (d.kind inside {K_BEQ, K_BNE, K_BLTZ, K_JR}) begin
      taken = (d.kind == K_BEQ && z) || (d.kind == K_BNE && !z) || (d.kind == K_BLTZ && n);
      o.pc_we = taken || d.kind == K_JR;
      o.pc_sel = d.kind == K_JR ? 2'd3 : taken ? 2'd1 : 2'd0;
      push(rb(), rb(), o, 1'b1);
      return;
    end
    push(rb(), rb(), o, 1'b0);
    if (d.kind inside {K_LD, K_LB, K_SW}) begin
      o = '0;
      o.dmem_req = 1'b1;
      o.dmem_we = d.kind == K_SW;
      for (int i = 0; i < dw; i++) push(rb(), 1'b0, o, 1'b0);
      push(rb(), 1'b1, o, d.kind == K_SW);
      if (d.kind == K_SW) return;
    end
    o = '0;
    o.reg_we = 1'b1;
    o.reg_dst = d.kind == K_R ? 2'd1 : 2'd0;
    o.mem2reg = d.kind == K_LD || d.kind == K_LB;
    o.lb = d.kind == K_LB;
    push(rb(), rb(), o, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cyc));
    chk({tag, " instr_cnt"}, 64'(instr_cnt), 64'(exp_ins));
  endtask

  task automatic run(input string tag, input int n);
    step_t s;
    for (int k = 0; k < n; k++) begin
      s = trace.pop_front();
      imem_ready = s.ir;
      dmem_ready = s.dr;
      #1;
      chk($sformatf("%s c%0d outs", tag, k), 64'(sample()), 64'(s.o));
      chk_cnt($sformatf("%s c%0d", tag, k));
      @(posedge clk);
      #1;
      exp_cyc = exp_cyc + 1'b1;
      exp_ins = exp_ins + CW'(s.ret);
    end
  endtask

  task automatic do_ins(input ins_t d, input int iw, input int dw, input logic z, input logic n, input string tag);
    opcode = d.op;
    funct = d.op == 6'h00 ? d.fn : 6'($urandom);
    zero = z;
    neg = n;
    build(d, iw, dw, z, n);
    run(tag, trace.size());
  endtask

  task automatic reset_and_check(input string tag);
    outs_t o;
    rst = 1'b1;
    #1;
    chk({tag, " reset-cycle outs"}, 64'(sample()), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ready = 1'b0;
    exp_cyc = '0;
    exp_ins = '0;
    trace.delete();
    #1;
    o = '0;
    o.imem_req = 1'b1;
    chk({tag, " post-reset outs"}, 64'(sample()), 64'(o));
    chk_cnt({tag, " post-reset"});
  endtask

  initial begin
    outs_t o;
    isa[0] = mk('h00, 'h20, K_R, 0, 0, 0, 0);   isa[1] = mk('h00, 'h21, K_R, 0, 0, 0, 0);
    isa[2] = mk('h00, 'h22, K_R, 1, 0, 0, 0);   isa[3] = mk('h00, 'h23, K_R, 1, 0, 0, 0);
    isa[4] = mk('h00, 'h24, K_R, 2, 0, 0, 0);   isa[5] = mk('h00, 'h25, K_R, 3, 0, 0, 0);
    isa[6] = mk('h00, 'h26, K_R, 4, 0, 0, 0);   isa[7] = mk('h00, 'h27, K_R, 5, 0, 0, 0);
    isa[8] = mk('h00, 'h2a, K_R, 6, 0, 0, 0);   isa[9] = mk('h00, 'h2b, K_R, 7, 0, 0, 0);
    isa[10] = mk('h00, 'h00, K_R, 8, 0, 0, 0);  isa[11] = mk('h00, 'h02, K_R, 9, 0, 0, 0);
    isa[12] = mk('h00, 'h03, K_R, 10, 0, 0, 0); isa[13] = mk('h00, 'h04, K_R, 8, 0, 0, 1);
    isa[14] = mk('h00, 'h08, K_JR, 0, 0, 0, 0); isa[15] = mk('h08, 0, K_I, 0, 1, 1, 0);
    isa[16] = mk('h09, 0, K_I, 0, 1, 1, 0);     isa[17] = mk('h0a, 0, K_I, 6, 1, 1, 0);
    isa[18] = mk('h0b, 0, K_I, 7, 1, 1, 0);     isa[19] = mk('h0c, 0, K_I, 2, 1, 0, 0);
    isa[20] = mk('h0d, 0, K_I, 3, 1, 0, 0);     isa[21] = mk('h0e, 0, K_I, 4, 1, 0, 0);
    isa[22] = mk('h0f, 0, K_I, 11, 1, 0, 0);    isa[23] = mk('h23, 0, K_LD, 0, 1, 1, 0);
    isa[24] = mk('h20, 0, K_LB, 0, 1, 1, 0);    isa[25] = mk('h2b, 0, K_SW, 0, 1, 1, 0);
    isa[26] = mk('h04, 0, K_BEQ, 1, 0, 1, 0);   isa[27] = mk('h05, 0, K_BNE, 1, 0, 1, 0);
    isa[28] = mk('h01, 0, K_BLTZ, 1, 0, 1, 0);  isa[29] = mk('h02, 0, K_J, 0, 0, 0, 0);
    isa[30] = mk('h03, 0, K_JAL, 0, 0, 0, 0);   isa[31] = mk('h3f, 0, K_ILL, 0, 0, 0, 0);
    isa[32] = mk('h00, 'h01, K_ILL, 0, 0, 0, 0); isa[33] = mk('h00, 'h0c, K_SYS, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    reset_and_check("init");

    do_ins(isa[I_ADD], 0, 0, 1'b0, 1'b0, "add");
    do_ins(isa[I_LW], 0, 3, 1'b0, 1'b0, "lw_wait3");
    do_ins(isa[I_BEQ], 0, 0, 1'b0, 1'b0, "beq_nt");
    do_ins(isa[I_BEQ], 0, 0, 1'b1, 1'b0, "beq_t");
    do_ins(isa[I_JAL], 0, 0, 1'b0, 1'b0, "jal");
    do_ins(isa[I_ILLOP], 0, 0, 1'b0, 1'b0, "illegal_3f");
    do_ins(isa[I_ADD], 2, 0, 1'b0, 1'b0, "add_after_illegal");

    // Enough traffic to wrap both 8-bit counters.
    for (int t = 0; t < 300; t++)
      do_ins(isa[$urandom_range(0, 32)], $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb(), $sformatf("rnd%0d", t));

    do_ins(isa[I_SYS], 1, 0, 1'b0, 1'b0, "syscall");
    for (int k = 0; k < 10; k++) begin
      imem_ready = rb();
      dmem_ready = rb();
      #1;
      o = '0;
      o.halted = 1'b1;
      chk($sformatf("halt c%0d outs", k), 64'(sample()), 64'(o));
      chk_cnt($sformatf("halt c%0d frozen", k));
      @(posedge clk);
      #1;
    end
    reset_and_check("halt_rst");
    do_ins(isa[I_ADD], 0, 0, 1'b0, 1'b0, "add_after_halt");

    opcode = isa[I_SW].op;
    funct = 6'($urandom);
    build(isa[I_SW], 0, 5, 1'b0, 1'b0);
    run("sw_pre_rst", 4);
    dmem_ready = 1'b0;
    reset_and_check("sw_mem_rst");
    do_ins(isa[I_SW], 0, 1, 1'b0, 1'b0, "sw_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
